// File: rtl/satd_acc.sv
// Pipelined 4x4 Hadamard SATD with first/last framed, saturating block accumulation.
// Stages: R1 vertical + first horizontal layer, R2 abs values, R3 tile_satd, R4 block outputs.
module satd_acc #(
    parameter int BITDEPTH = 8,
    parameter int ACC_W    = 24,
    parameter int CNT_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     in_first,
    input  logic                     in_last,
    input  logic [16*BITDEPTH-1:0]   cur_pix,
    input  logic [16*BITDEPTH-1:0]   ref_pix,
    output logic                     tile_valid,
    output logic [BITDEPTH+7:0]      tile_satd,
    output logic                     blk_valid,
    output logic [ACC_W-1:0]         blk_satd,
    output logic [CNT_W-1:0]         blk_tiles,
    output logic                     blk_ovf
);

    localparam int HW = BITDEPTH + 5;
    localparam int TW = BITDEPTH + 8;
    localparam int SW = BITDEPTH + 9;
    localparam int PW = ((ACC_W > TW) ? ACC_W : TW) + 1;
    localparam logic [PW-1:0] SAT_MAX = {{(PW-ACC_W){1'b0}}, {ACC_W{1'b1}}};

    logic signed [HW-1:0] d  [16];
    logic signed [HW-1:0] v  [16];
    logic signed [HW-1:0] h1 [16];
    logic signed [HW-1:0] h  [16];
    logic        [HW-1:0] habs [16];

    logic signed [HW-1:0] r1_q [16];
    logic        [HW-1:0] r2_q [16];
    logic                 r1_valid_q, r1_first_q, r1_last_q;
    logic                 r2_valid_q, r2_first_q, r2_last_q;
    logic                 r3_first_q, r3_last_q;
    logic [SW-1:0]        s;
    logic [TW-1:0]        tile_satd_d;

    // Stage 1: difference, full vertical transform, first horizontal butterfly layer.
    always_comb begin
        for (int k = 0; k < 16; k++) begin
            d[k] = $signed({{(HW-BITDEPTH){1'b0}}, ref_pix[(15-k)*BITDEPTH +: BITDEPTH]})
                 - $signed({{(HW-BITDEPTH){1'b0}}, cur_pix[(15-k)*BITDEPTH +: BITDEPTH]});
        end
        for (int c = 0; c < 4; c++) begin
            v[c]      = (d[c] + d[12+c]) + (d[4+c] + d[8+c]);
            v[4+c]    = (d[c] - d[12+c]) + (d[4+c] - d[8+c]);
            v[8+c]    = (d[c] + d[12+c]) - (d[4+c] + d[8+c]);
            v[12+c]   = (d[c] - d[12+c]) - (d[4+c] - d[8+c]);
        end
        for (int r = 0; r < 4; r++) begin
            h1[4*r]   = v[4*r]   + v[4*r+3];
            h1[4*r+1] = v[4*r+1] + v[4*r+2];
            h1[4*r+2] = v[4*r]   - v[4*r+3];
            h1[4*r+3] = v[4*r+1] - v[4*r+2];
        end
    end

    // Stage 2: second horizontal layer; h[0] is the DC term.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            h[4*r]   = r1_q[4*r]   + r1_q[4*r+1];
            h[4*r+1] = r1_q[4*r+2] + r1_q[4*r+3];
            h[4*r+2] = r1_q[4*r]   - r1_q[4*r+1];
            h[4*r+3] = r1_q[4*r+2] - r1_q[4*r+3];
        end
        for (int k = 0; k < 16; k++) begin
            habs[k] = h[k][HW-1] ? HW'(-h[k]) : HW'(h[k]);
        end
    end

    // Stage 3: DC is down-weighted by 4 before the sum, then the total is halved with rounding.
    always_comb begin
        s = SW'(r2_q[0] >> 2);
        for (int k = 1; k < 16; k++) begin
            s = s + SW'(r2_q[k]);
        end
        tile_satd_d = TW'((s + SW'(1)) >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid_q <= 1'b0;
            r1_first_q <= 1'b0;
            r1_last_q  <= 1'b0;
            r2_valid_q <= 1'b0;
            r2_first_q <= 1'b0;
            r2_last_q  <= 1'b0;
            tile_valid <= 1'b0;
            r3_first_q <= 1'b0;
            r3_last_q  <= 1'b0;
            tile_satd  <= '0;
            for (int k = 0; k < 16; k++) begin
                r1_q[k] <= '0;
                r2_q[k] <= '0;
            end
        end else begin
            r1_valid_q <= in_valid;
            r1_first_q <= in_first;
            r1_last_q  <= in_last;
            r2_valid_q <= r1_valid_q;
            r2_first_q <= r1_first_q;
            r2_last_q  <= r1_last_q;
            tile_valid <= r2_valid_q;
            r3_first_q <= r2_first_q;
            r3_last_q  <= r2_last_q;
            tile_satd  <= tile_satd_d;
            for (int k = 0; k < 16; k++) begin
                r1_q[k] <= h1[k];
                r2_q[k] <= habs[k];
            end
        end
    end

    // Stage 4: block accumulator.
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d, open_q, open_d;
    logic             start;
    logic [PW-1:0]    sum;
    logic             sat;
    logic             blk_valid_d;
    logic [ACC_W-1:0] blk_satd_d;
    logic [CNT_W-1:0] blk_tiles_d;
    logic             blk_ovf_d;

    always_comb begin
        start       = r3_first_q | ~open_q;
        sum         = (start ? '0 : PW'(acc_q)) + PW'(tile_satd);
        sat         = sum > SAT_MAX;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        open_d      = open_q;
        blk_valid_d = 1'b0;
        blk_satd_d  = blk_satd;
        blk_tiles_d = blk_tiles;
        blk_ovf_d   = blk_ovf;
        if (tile_valid) begin
            acc_d  = sat ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
            cnt_d  = (start ? '0 : cnt_q) + CNT_W'(1);
            ovf_d  = (start ? 1'b0 : ovf_q) | sat;
            open_d = ~r3_last_q;
            if (r3_last_q) begin
                blk_valid_d = 1'b1;
                blk_satd_d  = acc_d;
                blk_tiles_d = cnt_d;
                blk_ovf_d   = ovf_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            open_q    <= 1'b0;
            blk_valid <= 1'b0;
            blk_satd  <= '0;
            blk_tiles <= '0;
            blk_ovf   <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            open_q    <= open_d;
            blk_valid <= blk_valid_d;
            blk_satd  <= blk_satd_d;
            blk_tiles <= blk_tiles_d;
            blk_ovf   <= blk_ovf_d;
        end
    end

endmodule

// File: tb/tb_satd_acc.sv
// Directed bench for satd_acc: tile SATD values/latency and block framing, saturation, reset.
module tb_satd_acc;

    localparam int B = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
    logic [16*B-1:0]  cur_pix = '0, ref_pix = '0;

    logic             tile_valid, blk_valid, blk_ovf;
    logic [B+7:0]     tile_satd;
    logic [23:0]      blk_satd;
    logic [7:0]       blk_tiles;
    logic             tile_valid8, blk_valid8, blk_ovf8;
    logic [B+7:0]     tile_satd8;
    logic [7:0]       blk_satd8;
    logic [7:0]       blk_tiles8;

    satd_acc #(.BITDEPTH(B), .ACC_W(24), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .cur_pix(cur_pix), .ref_pix(ref_pix), .tile_valid(tile_valid), .tile_satd(tile_satd),
        .blk_valid(blk_valid), .blk_satd(blk_satd), .blk_tiles(blk_tiles), .blk_ovf(blk_ovf)
    );

    satd_acc #(.BITDEPTH(B), .ACC_W(8), .CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .cur_pix(cur_pix), .ref_pix(ref_pix), .tile_valid(tile_valid8), .tile_satd(tile_satd8),
        .blk_valid(blk_valid8), .blk_satd(blk_satd8), .blk_tiles(blk_tiles8), .blk_ovf(blk_ovf8)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    int last_cyc = 0;

    int got_t[$], got_tc[$], exp_t[$], exp_tc[$];
    int got_b[$], got_bn[$], got_bo[$], got_bc[$];
    int exp_b[$], exp_bn[$], exp_bo[$], exp_bc[$];
    int got8_b[$], got8_bn[$], got8_bo[$];
    int exp8_b[$], exp8_bn[$], exp8_bo[$];

    always @(negedge clk) begin
        if (tile_valid) begin
            got_t.push_back(int'(tile_satd));
            got_tc.push_back(cyc);
        end
        if (blk_valid) begin
            got_b.push_back(int'(blk_satd));
            got_bn.push_back(int'(blk_tiles));
            got_bo.push_back(int'(blk_ovf));
            got_bc.push_back(cyc);
        end
        if (blk_valid8) begin
            got8_b.push_back(int'(blk_satd8));
            got8_bn.push_back(int'(blk_tiles8));
            got8_bo.push_back(int'(blk_ovf8));
        end
    end

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [16*B-1:0] fill(input int val);
        logic [16*B-1:0] t;
        for (int k = 0; k < 16; k++) t[(15-k)*B +: B] = B'(val);
        return t;
    endfunction

    task automatic send(input bit v, input bit f, input bit l,
                        input logic [16*B-1:0] c, input logic [16*B-1:0] r, input int exp_tile);
        in_valid = v;
        in_first = f;
        in_last  = l;
        cur_pix  = c;
        ref_pix  = r;
        last_cyc = cyc;
        if (v) begin
            exp_t.push_back(exp_tile);
            exp_tc.push_back(cyc + 3);
        end
        @(posedge clk);
        #1;
    endtask

    // Gap cycle with flags and data that must all be ignored.
    task automatic gap();
        in_valid = 1'b0;
        in_first = 1'b1;
        in_last  = 1'b1;
        cur_pix  = fill(0);
        ref_pix  = fill(255);
        @(posedge clk);
        #1;
    endtask

    task automatic exp_blk(input int satd, input int tiles, input int ovf);
        exp_b.push_back(satd);
        exp_bn.push_back(tiles);
        exp_bo.push_back(ovf);
        exp_bc.push_back(last_cyc + 4);
    endtask

    task automatic exp_blk8(input int satd, input int tiles, input int ovf);
        exp8_b.push_back(satd);
        exp8_bn.push_back(tiles);
        exp8_bo.push_back(ovf);
    endtask

    task automatic settle_and_compare(input string tag, input bit chk8);
        int n;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check_val({tag, " tile count"}, got_t.size(), exp_t.size());
        n = (got_t.size() < exp_t.size()) ? got_t.size() : exp_t.size();
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("%s tile%0d satd", tag, i), got_t[i], exp_t[i]);
            check_val($sformatf("%s tile%0d cycle", tag, i), got_tc[i], exp_tc[i]);
        end
        check_val({tag, " blk count"}, got_b.size(), exp_b.size());
        n = (got_b.size() < exp_b.size()) ? got_b.size() : exp_b.size();
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("%s blk%0d satd", tag, i), got_b[i], exp_b[i]);
            check_val($sformatf("%s blk%0d tiles", tag, i), got_bn[i], exp_bn[i]);
            check_val($sformatf("%s blk%0d ovf", tag, i), got_bo[i], exp_bo[i]);
            check_val($sformatf("%s blk%0d cycle", tag, i), got_bc[i], exp_bc[i]);
        end
        if (chk8) begin
            check_val({tag, " acc8 blk count"}, got8_b.size(), exp8_b.size());
            n = (got8_b.size() < exp8_b.size()) ? got8_b.size() : exp8_b.size();
            for (int i = 0; i < n; i++) begin
                check_val($sformatf("%s acc8 blk%0d satd", tag, i), got8_b[i], exp8_b[i]);
                check_val($sformatf("%s acc8 blk%0d tiles", tag, i), got8_bn[i], exp8_bn[i]);
                check_val($sformatf("%s acc8 blk%0d ovf", tag, i), got8_bo[i], exp8_bo[i]);
            end
        end
        got_t.delete();  got_tc.delete(); exp_t.delete();  exp_tc.delete();
        got_b.delete();  got_bn.delete(); got_bo.delete(); got_bc.delete();
        exp_b.delete();  exp_bn.delete(); exp_bo.delete(); exp_bc.delete();
        got8_b.delete(); got8_bn.delete(); got8_bo.delete();
        exp8_b.delete(); exp8_bn.delete(); exp8_bo.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, " tile_valid"}, tile_valid, 0);
        check_val({tag, " blk_valid"}, blk_valid, 0);
        check_val({tag, " blk_satd"}, blk_satd, 0);
        check_val({tag, " blk_tiles"}, blk_tiles, 0);
        check_val({tag, " blk_ovf"}, blk_ovf, 0);
    endtask

    logic [16*B-1:0] c10, r10, z, f255;

    initial begin
        c10  = fill(100);
        r10  = c10;
        r10[16*B-1 -: B] = B'(110);
        z    = fill(0);
        f255 = fill(255);

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Identical tiles give zero.
        send(1, 1, 1, fill(37), fill(37), 0);
        exp_blk(0, 1, 0);
        settle_and_compare("zero", 1'b0);

        // Uniform +1 offset: only DC=16 -> 4 -> 2; full-scale DC -> 510.
        send(1, 1, 1, fill(5), fill(6), 2);
        exp_blk(2, 1, 0);
        send(1, 1, 1, z, f255, 510);
        exp_blk(510, 1, 0);
        settle_and_compare("uniform", 1'b0);

        // Single-pixel delta of 10: every |H|=10 -> 76 per tile; 4 tiles saturate an 8-bit acc.
        send(1, 1, 0, c10, r10, 76);
        send(1, 0, 0, c10, r10, 76);
        send(1, 0, 0, c10, r10, 76);
        send(1, 0, 1, c10, r10, 76);
        exp_blk(304, 4, 0);
        exp_blk8(255, 4, 1);
        send(1, 1, 1, fill(9), fill(9), 0);
        exp_blk(0, 1, 0);
        exp_blk8(0, 1, 0);
        settle_and_compare("four", 1'b1);

        // Block A (2 tiles) then block B (3 tiles) with ignored gaps inside B.
        send(1, 1, 0, c10, r10, 76);
        send(1, 0, 1, c10, r10, 76);
        exp_blk(152, 2, 0);
        send(1, 1, 0, z, f255, 510);
        gap();
        send(1, 0, 0, fill(5), fill(6), 2);
        gap();
        gap();
        send(1, 0, 1, c10, r10, 76);
        exp_blk(588, 3, 0);
        settle_and_compare("ab", 1'b0);

        // A second first abandons the partial 510.
        send(1, 1, 0, z, f255, 510);
        send(1, 1, 0, c10, r10, 76);
        send(1, 0, 1, fill(5), fill(6), 2);
        exp_blk(78, 2, 0);
        settle_and_compare("refirst", 1'b0);

        // Reset with two tiles in flight: outputs clear at once, nothing emerges later.
        send(1, 1, 0, z, f255, 510);
        send(1, 0, 0, z, f255, 510);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        exp_t.delete();
        exp_tc.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Tile with only last while closed starts its own block.
        send(1, 0, 1, c10, r10, 76);
        exp_blk(76, 1, 0);
        settle_and_compare("postrst", 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got %0d expected %0d", cyc, 0);
        $fatal(1);
    end

endmodule
